// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the bit-serial ALU sequencer.
//   - cmd encodings CMD_AND..CMD_XNOR
//   - alu1bit slice op codes OP_AND, OP_OR, OP_ADD, OP_XOR
//   - sequencer FSM state encoding
//   - decode of a cmd into the slice controls plus initial carry
package alu_pkg;

  localparam logic [2:0] CMD_AND  = 3'd0;
  localparam logic [2:0] CMD_OR   = 3'd1;
  localparam logic [2:0] CMD_ADD  = 3'd2;
  localparam logic [2:0] CMD_SUB  = 3'd3;
  localparam logic [2:0] CMD_XOR  = 3'd4;
  localparam logic [2:0] CMD_NOR  = 3'd5;
  localparam logic [2:0] CMD_NAND = 3'd6;
  localparam logic [2:0] CMD_XNOR = 3'd7;

  // The top op bit is reserved and always 0 for the four slice functions.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       ainvert;
    logic       binvert;
    logic [2:0] op;
    logic       cin0;
    logic       arith;   // ADD/SUB: carry out (and overflow) are meaningful
  } ctrl_t;

  function automatic ctrl_t decode_cmd(input logic [2:0] cmd);
    ctrl_t c;
    c = '{ainvert: 1'b0, binvert: 1'b0, op: OP_AND, cin0: 1'b0, arith: 1'b0};
    case (cmd)
      CMD_AND:  c = '{1'b0, 1'b0, OP_AND, 1'b0, 1'b0};
      CMD_OR:   c = '{1'b0, 1'b0, OP_OR,  1'b0, 1'b0};
      CMD_ADD:  c = '{1'b0, 1'b0, OP_ADD, 1'b0, 1'b1};
      CMD_SUB:  c = '{1'b0, 1'b1, OP_ADD, 1'b1, 1'b1};
      CMD_XOR:  c = '{1'b0, 1'b0, OP_XOR, 1'b0, 1'b0};
      CMD_NOR:  c = '{1'b1, 1'b1, OP_AND, 1'b0, 1'b0};
      CMD_NAND: c = '{1'b1, 1'b1, OP_OR,  1'b0, 1'b0};
      CMD_XNOR: c = '{1'b1, 1'b0, OP_XOR, 1'b0, 1'b0};
      default:  c = '{1'b0, 1'b0, OP_AND, 1'b0, 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu1bit.sv
// alu1bit: one-bit ALU slice (combinational).
// Ports:
//   a, b      operand bits
//   cin       carry in
//   ainvert   invert a before the function
//   binvert   invert b before the function
//   op[2:0]   function select (OP_AND/OP_OR/OP_ADD/OP_XOR)
//   result    function output
//   cout      full-adder carry out of the (possibly inverted) operands
module alu1bit
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout
);

  logic aa;
  logic bb;

  assign aa   = a ^ ainvert;
  assign bb   = b ^ binvert;
  assign cout = (aa & bb) | (aa & cin) | (bb & cin);

  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = aa & bb;
      OP_OR:   result = aa | bb;
      OP_ADD:  result = aa ^ bb ^ cin;
      OP_XOR:  result = aa ^ bb;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer. Computes a WIDTH-bit operation
// on a single alu1bit slice, one bit per clock, LSB first.
// Optional feature macro: ALU_SERIAL_FLAGS_EN adds zero_flag and ovf_flag.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start_valid/ready command handshake (ready only in IDLE)
//   cmd, a_in, b_in   operation and operands, captured at accept
//   res_valid/ready   result handshake (valid only in DONE)
//   result, cout_out  result and MSB carry (carry only for ADD/SUB)
//   busy              high in RUN or DONE
//   zero_flag         (flags build) result is zero
//   ovf_flag          (flags build) signed overflow for ADD/SUB
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid does not depend on ready.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout_out,
`ifdef ALU_SERIAL_FLAGS_EN
  output logic             zero_flag,
  output logic             ovf_flag,
`endif
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  ctrl_t            ctrl;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             slice_res;
  logic             slice_cout;
  logic             accept;
  logic             last_bit;

  alu1bit u_slice (
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .cin     (carry),
    .ainvert (ctrl.ainvert),
    .binvert (ctrl.binvert),
    .op      (ctrl.op),
    .result  (slice_res),
    .cout    (slice_cout)
  );

  assign accept   = start_valid && start_ready;
  assign last_bit = (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and handshake outputs
  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (state)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: nothing changes in DONE, so the result is held under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl   <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      ctrl   <= decode_cmd(cmd);
      a_sh   <= a_in;
      b_sh   <= b_in;
      res_sh <= '0;
      carry  <= decode_cmd(cmd).cin0;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {slice_res, res_sh[WIDTH-1:1]};
      carry  <= slice_cout;
      cnt    <= cnt + 1'b1;
    end
  end

  assign result   = res_valid ? res_sh : '0;
  assign cout_out = res_valid & ctrl.arith & carry;

`ifdef ALU_SERIAL_FLAGS_EN
  // On the last RUN cycle 'carry' is the carry into the MSB.
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (reset || accept)                ovf_q <= 1'b0;
    else if (state == ST_RUN && last_bit) ovf_q <= ctrl.arith & (carry ^ slice_cout);
  end

  assign zero_flag = res_valid && (res_sh == '0);
  assign ovf_flag  = res_valid & ovf_q;
`endif

endmodule
